// File: rtl/gpio_pin_arbiter.sv
// Shares the breakout GPIO pads among team designs. Owners are staged in shadow registers and
// committed atomically; every pin that changes owner is held tristate before the new owner drives it.

module gpio_pin_mux #(
  parameter int NUM_TEAMS = 12
) (
  input  logic [7:0]           owner_i,
  input  logic                 blank_i,
  input  logic [NUM_TEAMS-1:0] team_out_i,
  input  logic [NUM_TEAMS-1:0] team_oeb_i,
  output logic                 out_o,
  output logic                 oeb_o
);
  // Owner 0 and out-of-range owners fall through to the tristate default.
  always_comb begin
    out_o = 1'b0;
    oeb_o = 1'b1;
    if (!blank_i) begin
      for (int t = 0; t < NUM_TEAMS; t++) begin
        if (owner_i == 8'(t + 1)) begin
          out_o = team_out_i[t];
          oeb_o = team_oeb_i[t];
        end
      end
    end
  end
endmodule

module gpio_pin_arbiter #(
  parameter int NUM_TEAMS    = 12,
  parameter int NUM_PINS     = 34,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_PINS*NUM_TEAMS-1:0] designs_gpio_out,
  input  logic [NUM_PINS*NUM_TEAMS-1:0] designs_gpio_oeb,
  output logic [NUM_PINS-1:0]           gpio_out,
  output logic [NUM_PINS-1:0]           gpio_oeb,
  output logic                          busy_o
);
  localparam int NUM_WORDS = (NUM_PINS + 3) / 4;
  localparam int PAD_BITS  = NUM_WORDS * 32 - NUM_PINS * 8;

  localparam logic [5:0] W_COMMIT = 6'd9;
  localparam logic [5:0] W_STATUS = 6'd10;
  localparam logic [5:0] W_ACT0   = 6'd11;
  localparam logic [5:0] W_ACTN   = 6'd19;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_APPLY} state_e;

  state_e                    state_q;
  logic [NUM_PINS-1:0][7:0]  shadow_q, active_q, pend_q;
  logic [NUM_PINS-1:0]       blank_q;
  logic [7:0]                cnt_q;
  logic                      overrun_q;
  logic                      ack_q;
  logic [31:0]               dat_q;

  logic [NUM_WORDS-1:0][31:0] shadow_w, active_w;
  logic [NUM_PINS-1:0]        chg_d;
  logic [31:0]                rdat_d;
  logic [5:0]                 wi, aw;
  logic                       req, act, wr_sh, commit, st_clr;

  logic unused;
  assign unused = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  assign wi     = wbs_adr_i[7:2];
  assign aw     = wi - W_ACT0;
  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  // Register side effects land at the ack cycle, while the master still holds the request.
  assign act    = wbs_stb_i & wbs_cyc_i & ack_q;
  assign wr_sh  = act & wbs_we_i & (wi < W_COMMIT);
  assign commit = act & wbs_we_i & (wi == W_COMMIT);
  assign st_clr = act & wbs_we_i & (wi == W_STATUS) & wbs_sel_i[0] & wbs_dat_i[1];

  assign shadow_w = {{PAD_BITS{1'b0}}, shadow_q};
  assign active_w = {{PAD_BITS{1'b0}}, active_q};

  assign busy_o    = (state_q != S_IDLE);
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  always_comb begin
    for (int p = 0; p < NUM_PINS; p++) chg_d[p] = (shadow_q[p] != active_q[p]);
  end

  always_comb begin
    rdat_d = '0;
    if (wi < W_COMMIT)                    rdat_d = shadow_w[wi[3:0]];
    else if (wi == W_STATUS)              rdat_d = {30'b0, overrun_q, busy_o};
    else if (wi >= W_ACT0 && wi <= W_ACTN) rdat_d = active_w[aw[3:0]];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      shadow_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdat_d : 32'h0;
      for (int p = 0; p < NUM_PINS; p++) begin
        if (wr_sh && wi == 6'(p / 4) && wbs_sel_i[p % 4])
          shadow_q[p] <= wbs_dat_i[8*(p%4) +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      active_q  <= '0;
      pend_q    <= '0;
      blank_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (st_clr) overrun_q <= 1'b0;
      if (commit && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (commit) begin
            pend_q  <= shadow_q;
            blank_q <= chg_d;
            if (|chg_d) begin
              state_q <= S_BLANK;
              cnt_q   <= 8'(GUARD_CYCLES - 1);
            end else begin
              state_q <= S_APPLY;
            end
          end
        end
        S_BLANK: begin
          if (cnt_q == 8'd0) state_q <= S_APPLY;
          else               cnt_q   <= cnt_q - 8'd1;
        end
        S_APPLY: begin
          active_q <= pend_q;
          blank_q  <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [NUM_TEAMS-1:0] t_out, t_oeb;
    for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
      assign t_out[t] = designs_gpio_out[NUM_PINS*t + p];
      assign t_oeb[t] = designs_gpio_oeb[NUM_PINS*t + p];
    end
    gpio_pin_mux #(.NUM_TEAMS(NUM_TEAMS)) u_mux (
      .owner_i    (active_q[p]),
      .blank_i    (blank_q[p]),
      .team_out_i (t_out),
      .team_oeb_i (t_oeb),
      .out_o      (gpio_out[p]),
      .oeb_o      (gpio_oeb[p])
    );
  end
endmodule
